text_buffer: RTL and testbench
==============================

# text_buffer

Character-cell memory feeding the VGA character generator. The host writes ASCII codes through a byte-wide register port with an auto-incrementing cursor. The display side uses the signal generator's `horicount`/`vertcount` to prefetch one 8×8 cell ahead and presents a stable `character` code for each 8-pixel cell. It replaces the fixed test character in the mini-VGA top level, sitting between the host bus and `chargen`.

## Interface
- `COLS`, 80, text columns (640 px / 8)
- `ROWS`, 60, text rows (480 px / 8)
- `H_TOTAL`, 800, horizontal count period of the signal generator
- `V_TOTAL`, 525, vertical count period of the signal generator
- `clk  in  1  pixel clock; all logic on rising edge`
- `reset  in  1  synchronous, active-high reset`
- `wr_valid  in  1  host write request`
- `wr_ready  out  1  write accepted on edge where wr_valid && wr_ready`
- `wr_reg  in  2  0=data, 1=cursor low byte, 2=cursor high byte, 3=control`
- `wr_data  in  8  write payload`
- `horicount  in  10  horizontal pixel count from signal generator`
- `vertcount  in  10  vertical line count from signal generator`
- `character  out  8  code of the cell being displayed`
- `cursor_on  out  1  high while the displayed cell is the blinking cursor cell`

## Operation
- Storage: `CELLS = COLS*ROWS` bytes. One write port (host), one registered read port (display). Same-address same-cycle access is read-before-write.
- Cursor: `CW = $clog2(CELLS)` bits; 13 at default.
- `wr_reg=0`: store `wr_data` at the cursor. Cursor increments and wraps from `CELLS-1` to 0.
- `wr_reg=1`: sets cursor[7:0].
- `wr_reg=2`: sets cursor[CW-1:8]; upper bits of `wr_data` are ignored.
- After a cursor write, a value ≥ CELLS forces the cursor to 0.
- `wr_reg=3`: bit0=1 starts a clear; other bits are ignored.
- FSM `CLEAR`: one cell per cycle, addresses 0..CELLS-1, filled with 0x20. Cursor is set to 0. `wr_ready`=0 throughout.
- FSM `IDLE`: `wr_ready`=1.
- Transitions:
  - `reset` → `CLEAR`.
  - `CLEAR` → `IDLE` after address CELLS-1 is written.
  - Control write with bit0=1 in `IDLE` → `CLEAR`.
- Display prefetch:
  - Next cell is `col = (horicount>>3)+1`, `row = vertcount>>3`.
  - If `horicount ≥ H_TOTAL-8`: `col = 0` and `row` is taken from `vertcount+1`, with `V_TOTAL-1` wrapping to 0.
- Next cell is blank (0x20, no RAM use) when `col ≥ COLS` or `row ≥ ROWS`.

## Timing
- Reset values:
  - `character` = 0x20, `cursor_on` = 0, `wr_ready` = 0 (clear starts), cursor = 0.
- Clear takes exactly CELLS cycles: `wr_ready` rises on the cycle after address CELLS-1 is written.
- Read pipeline:
  - Cycle with `horicount[2:0]==6`: address presented.
  - Cycle with `[2:0]==7`: RAM data valid.
  - `character` loads at the end of the `[2:0]==7` cycle.
- Result: `character` is stable for all 8 pixels with `horicount[2:0]==0..7` of its cell. It never changes at any other phase.
- During CLEAR the display read still runs. Cells not yet cleared show undefined codes for at most one frame.
- A host write is visible on screen no earlier than the next fetch of that cell.
- Reset mid-clear restarts the clear from address 0.
- A control write during CLEAR is impossible, since `wr_ready`=0.

## Configuration
- `TEXT_BUFFER_CURSOR_EN` defined:
  - A frame counter increments each time `vertcount` wraps to 0.
  - Blink phase is bit 4 (16 frames on, 16 off).
  - `cursor_on` loads together with `character`: 1 when the fetched cell address equals the cursor and the blink phase is 1.
  - Cursor is suppressed in CLEAR.
- Undefined: no frame counter; `cursor_on` is tied to 0.

## Test plan
- Reset, hold `wr_valid`=0 → `wr_ready`=0 for 4800 cycles then 1. Every visible cell displays 0x20.
- Write cursor lo=0x4F and hi=0x00 (cell 79), then data 0x41 → 'A' appears at the last column of row 0. Next data 0x42 lands at row 1, col 0.
- Cursor set to 4799, write 0x43 → cursor wraps to 0; the next data byte lands in cell 0. Cursor hi=0x1F → cursor forced to 0.
- Display timing with cell (2,1)=0x58 → `character`=0x58 exactly while `vertcount` in 8..15 and `horicount` in 16..23. It is 0x20 for `horicount` ≥ 640.
- Control write 0x01 after filling text → `wr_ready` low 4800 cycles, all cells 0x20. Assert `reset` at cycle 100 of the clear → the clear restarts, `wr_ready` low 4800 more cycles.
- With `TEXT_BUFFER_CURSOR_EN`, cursor at cell 5 → `cursor_on`=1 only in cell 5 during frames 16–31, 48–63 and the matching phases after. Without the macro → always 0.

Source files
------------

// File: rtl/text_buffer.sv
// text_buffer: host-written character-cell RAM, one-cell-ahead display fetch.
// Ports: clk, reset, wr_valid/wr_ready/wr_reg/wr_data (host), horicount/vertcount in, character/cursor_on out.
// Option: TEXT_BUFFER_CURSOR_EN adds a frame counter and a blinking cursor flag.
module text_buffer #(
  parameter int COLS    = 80,
  parameter int ROWS    = 60,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_reg,
  input  logic [7:0] wr_data,
  input  logic [9:0] horicount,
  input  logic [9:0] vertcount,
  output logic [7:0] character,
  output logic       cursor_on
);

  localparam int CELLS = COLS * ROWS;
  localparam int CW    = $clog2(CELLS);

  localparam logic [CW-1:0] LAST  = CW'(CELLS - 1);
  localparam logic [CW:0]   NCELL = (CW+1)'(CELLS);
  localparam logic [7:0]    BLANK = 8'h20;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [7:0]    mem [CELLS];
  logic [7:0]    rdata;
  logic [0:0]    state;
  logic [CW-1:0] clr_addr;
  logic [CW-1:0] cursor;

  logic          wr_fire;
  logic [CW-1:0] cur_lo;
  logic [CW-1:0] cur_hi;
  logic [CW-1:0] cur_inc;

  logic          mem_we;
  logic [CW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;

  assign wr_ready = (state == IDLE);
  assign wr_fire  = wr_valid && wr_ready;

  assign cur_lo  = {cursor[CW-1:8], wr_data};
  assign cur_hi  = {wr_data[CW-9:0], cursor[7:0]};
  assign cur_inc = (cursor == LAST) ? '0 : cursor + 1'b1;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cursor;
    mem_wdata = wr_data;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = BLANK;
    end else if (wr_fire && wr_reg == 2'd0) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      cursor   <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          cursor <= '0;
          if (clr_addr == LAST) begin
            state    <= IDLE;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        IDLE: begin
          if (wr_fire) begin
            case (wr_reg)
              2'd0: cursor <= cur_inc;
              2'd1: cursor <= ({1'b0, cur_lo} >= NCELL) ? '0 : cur_lo;
              2'd2: cursor <= ({1'b0, cur_hi} >= NCELL) ? '0 : cur_hi;
              default: begin
                if (wr_data[0]) begin
                  state    <= CLEAR;
                  clr_addr <= '0;
                  cursor   <= '0;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  // Prefetch: address the cell to the right of the current one,
  // or column 0 of the next line during the last 8 counts of a line.
  logic [2:0]    phase;
  logic [9:0]    vnext;
  logic [9:0]    col;
  logic [9:0]    row;
  logic          blank;
  logic          blank_q;
  logic [CW-1:0] fetch_addr;

  assign phase = horicount[2:0];

  always_comb begin
    if (vertcount == 10'(V_TOTAL - 1)) vnext = '0;
    else vnext = vertcount + 10'd1;
    if (horicount >= 10'(H_TOTAL - 8)) begin
      col = '0;
      row = vnext >> 3;
    end else begin
      col = (horicount >> 3) + 10'd1;
      row = vertcount >> 3;
    end
  end

  assign blank = (col >= 10'(COLS)) || (row >= 10'(ROWS));
  assign fetch_addr = CW'(row) * CW'(COLS) + CW'(col);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (phase == 3'd6 && !blank) rdata <= mem[fetch_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q   <= 1'b1;
      character <= BLANK;
    end else begin
      if (phase == 3'd6) blank_q <= blank;
      if (phase == 3'd7) character <= blank_q ? BLANK : rdata;
    end
  end

`ifdef TEXT_BUFFER_CURSOR_EN
  logic [9:0]    vc_q;
  logic [4:0]    frame;
  logic [CW-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vc_q      <= '0;
      frame     <= '0;
      addr_q    <= '0;
      cursor_on <= 1'b0;
    end else begin
      vc_q <= vertcount;
      if (vertcount == '0 && vc_q != '0) frame <= frame + 1'b1;
      if (phase == 3'd6) addr_q <= fetch_addr;
      if (phase == 3'd7)
        cursor_on <= !blank_q && (state == IDLE) &&
                     (addr_q == cursor) && frame[4];
    end
  end
`else
  assign cursor_on = 1'b0;
`endif

endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: directed checks of text_buffer clear, host writes,
// cursor wrap, display fetch timing and cursor flag.
module tb_text_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_reg = '0;
  logic [7:0] wr_data = '0;
  logic [9:0] horicount = '0;
  logic [9:0] vertcount = '0;
  logic [7:0] character;
  logic       cursor_on;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] model [4800];
  int cur = 0;

  text_buffer dut (
    .clk(clk),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_reg(wr_reg),
    .wr_data(wr_data),
    .horicount(horicount),
    .vertcount(vertcount),
    .character(character),
    .cursor_on(cursor_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4800; i++) model[i] = 8'h20;
    cur = 0;
  endtask

  task automatic wr(input logic [1:0] r, input logic [7:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_reg = r;
    wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
    case (r)
      2'd0: begin
        model[cur] = d;
        cur = (cur == 4799) ? 0 : cur + 1;
      end
      2'd1: begin
        cur = (cur & 32'h1F00) | int'(d);
        if (cur >= 4800) cur = 0;
      end
      2'd2: begin
        cur = ((int'(d) & 31) << 8) | (cur & 255);
        if (cur >= 4800) cur = 0;
      end
      default: if (d[0]) model_clear();
    endcase
  endtask

  task automatic fetch_cell(input int c, input int r,
                            output logic [7:0] ch, output logic co);
    @(negedge clk);
    if (c == 0) begin
      vertcount = (r == 0) ? 10'd524 : 10'(r * 8 - 1);
      horicount = 10'd798;
      @(negedge clk);
      horicount = 10'd799;
    end else begin
      vertcount = 10'(r * 8);
      horicount = 10'(c * 8 - 2);
      @(negedge clk);
      horicount = 10'(c * 8 - 1);
    end
    @(negedge clk);
    vertcount = 10'(r * 8);
    horicount = 10'(c * 8);
    ch = character;
    co = cursor_on;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (wr_ready !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic scan_all(output int bad);
    logic [7:0] ch;
    logic co;
    bad = 0;
    for (int r = 0; r < 60; r++)
      for (int c = 0; c < 80; c++) begin
        fetch_cell(c, r, ch, co);
        if (ch !== model[r * 80 + c]) bad++;
      end
  endtask

  task automatic bump_frames(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      vertcount = 10'd1;
      @(negedge clk);
      vertcount = 10'd0;
    end
  endtask

  logic exp_co;

  initial begin
    int n;
    int bad;
    int n58;
    int nco;
    logic [7:0] ch;
    logic co;
    logic [7:0] e;

    model_clear();
    repeat (2) @(negedge clk);
    check("rst_ready", wr_ready, 1'b0);
    check("rst_char", character, 8'h20);
    check("rst_cursor_on", cursor_on, 1'b0);
    reset = 1'b0;
    wait_ready(n);
    check("clear_cycles", n, 4800);
    scan_all(bad);
    check("scan_after_reset", bad, 0);

    wr(2'd1, 8'h4F);
    wr(2'd2, 8'h00);
    wr(2'd0, 8'h41);
    wr(2'd0, 8'h42);
    fetch_cell(79, 0, ch, co);
    check("cell_79_0", ch, 8'h41);
    fetch_cell(0, 1, ch, co);
    check("cell_0_1", ch, 8'h42);
    fetch_cell(80, 0, ch, co);
    check("col80_blank", ch, 8'h20);

    wr(2'd1, 8'hBF);
    wr(2'd2, 8'h12);
    wr(2'd0, 8'h43);
    wr(2'd0, 8'h44);
    fetch_cell(79, 59, ch, co);
    check("cell_4799", ch, 8'h43);
    fetch_cell(0, 0, ch, co);
    check("wrap_cell0", ch, 8'h44);
    wr(2'd2, 8'h1F);
    wr(2'd0, 8'h45);
    fetch_cell(0, 0, ch, co);
    check("hi_ovf_to_0", ch, 8'h45);
    wr(2'd1, 8'h02);
    wr(2'd2, 8'hE0);
    wr(2'd0, 8'h46);
    fetch_cell(2, 0, ch, co);
    check("hi_upper_ign", ch, 8'h46);

    wr(2'd1, 8'd82);
    wr(2'd2, 8'h00);
    wr(2'd0, 8'h58);
    bad = 0;
    n58 = 0;
    nco = 0;
    for (int v = 7; v <= 16; v++)
      for (int h = 0; h < 800; h++) begin
        @(negedge clk);
        vertcount = 10'(v);
        horicount = 10'(h);
        if (!(v == 7 && h < 8)) begin
          e = (h < 640 && v < 480) ? model[(v / 8) * 80 + h / 8] : 8'h20;
          if (character !== e) bad++;
          if (character === 8'h58) n58++;
          if (cursor_on !== 1'b0) nco++;
        end
      end
    check("sweep_mismatch", bad, 0);
    check("sweep_58_pixels", n58, 64);
`ifndef TEXT_BUFFER_CURSOR_EN
    check("sweep_cursor_off", nco, 0);
`endif

    wr(2'd3, 8'hFE);
    check("ctl_bit0_clear", wr_ready, 1'b1);
    wr(2'd3, 8'h01);
    wait_ready(n);
    check("ctl_clear_cycles", n, 4800);
    scan_all(bad);
    check("scan_after_ctl", bad, 0);
    wr(2'd0, 8'h31);
    fetch_cell(0, 0, ch, co);
    check("clear_cursor0", ch, 8'h31);

    wr(2'd3, 8'h01);
    repeat (99) @(negedge clk);
    check("mid_clear_busy", wr_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    horicount = '0;
    vertcount = '0;
    wait_ready(n);
    check("restart_cycles", n, 4800);
    check("restart_char", character, 8'h20);

    wr(2'd1, 8'h05);
    wr(2'd2, 8'h00);
    fetch_cell(5, 0, ch, co);
    check("cur_frame0", co, 1'b0);
    bump_frames(16);
`ifdef TEXT_BUFFER_CURSOR_EN
    exp_co = 1'b1;
`else
    exp_co = 1'b0;
`endif
    fetch_cell(5, 0, ch, co);
    check("cur_frame16", co, exp_co);
    fetch_cell(4, 0, ch, co);
    check("cur_cell4", co, 1'b0);
    fetch_cell(6, 0, ch, co);
    check("cur_cell6", co, 1'b0);
    bump_frames(16);
    fetch_cell(5, 0, ch, co);
    check("cur_frame32", co, 1'b0);
    bump_frames(16);
    fetch_cell(5, 0, ch, co);
    check("cur_frame48", co, exp_co);
    check("cur_cell_char", ch, 8'h20);

    fetch_cell(0, 0, ch, co);
    check("restart_cell0", ch, 8'h20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
